mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with EX/MEM and MEM/WB registers, data-memory handshake and access timeout.
// Optional misaligned-access trap is enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
package mem_stage_pkg;
    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic MemRead;
        logic MemWrite;
    } control_type;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  control_type control_in,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    output logic        stall_out,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_RegWrite,
    output logic [31:0] forward_ex_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_out,
    output logic        err_out
);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return (size[1] && addr != 2'b00) || (size == 2'b01 && addr[0]);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ex_valid_q, ex_valid_d;
    control_type ex_ctrl_q, ex_ctrl_d;
    logic [31:0] ex_alu_q, ex_alu_d;
    logic [31:0] ex_wd_q, ex_wd_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [2:0]  ex_f3_q, ex_f3_d;
    logic        wb_valid_q, wb_valid_d;
    control_type wb_ctrl_q, wb_ctrl_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_mem_q, wb_mem_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_err_q, wb_err_d;

    logic        busy, timeout, stall;
    control_type in_ctrl, done_ctrl;
    logic        in_mem, in_trap, cur_mem, cur_trap, done_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data, wdata_rep;
    logic [3:0]  be;

    always_comb begin
        busy      = state_q == BUSY;
        timeout   = busy && !dmem_gnt && cnt_q == CNT_LAST;
        stall     = busy && !dmem_gnt && !timeout;
        // Bubbles must never write the register file or touch memory.
        in_ctrl          = control_in;
        in_ctrl.RegWrite = control_in.RegWrite & ex_valid;
        in_ctrl.MemRead  = control_in.MemRead & ex_valid;
        in_ctrl.MemWrite = control_in.MemWrite & ex_valid;
        in_mem    = in_ctrl.MemRead | in_ctrl.MemWrite;
        in_trap   = TRAP_EN && in_mem && misaligned(funct3_in[1:0], alu_data[1:0]);
        cur_mem   = ex_ctrl_q.MemRead | ex_ctrl_q.MemWrite;
        cur_trap  = TRAP_EN && cur_mem && misaligned(ex_f3_q[1:0], ex_alu_q[1:0]);
        done_err  = timeout || cur_trap;
        ex_valid_d = stall ? ex_valid_q : ex_valid;
        ex_ctrl_d  = stall ? ex_ctrl_q : in_ctrl;
        ex_alu_d   = stall ? ex_alu_q : alu_data;
        ex_wd_d    = stall ? ex_wd_q : memory_data;
        ex_pc_d    = stall ? ex_pc_q : pc_in;
        ex_rd_d    = stall ? ex_rd_q : rd_in;
        ex_f3_d    = stall ? ex_f3_q : funct3_in;
        state_d    = stall ? state_q : (in_mem && !in_trap) ? BUSY : IDLE;
        cnt_d      = stall ? cnt_q + 8'd1 : 8'd0;
        ld_byte    = dmem_rdata[{ex_alu_q[1:0], 3'b000} +: 8];
        ld_half    = ex_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data  = (ex_f3_q == 3'b000) ? {{24{ld_byte[7]}}, ld_byte} :
                     (ex_f3_q == 3'b001) ? {{16{ld_half[15]}}, ld_half} :
                     (ex_f3_q == 3'b100) ? {24'd0, ld_byte} :
                     (ex_f3_q == 3'b101) ? {16'd0, ld_half} : dmem_rdata;
        be         = ex_f3_q[1] ? 4'hF :
                     ex_f3_q[0] ? (ex_alu_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ex_alu_q[1:0];
        wdata_rep  = ex_f3_q[1] ? ex_wd_q :
                     ex_f3_q[0] ? {2{ex_wd_q[15:0]}} : {4{ex_wd_q[7:0]}};
        done_ctrl          = ex_ctrl_q;
        done_ctrl.RegWrite = ex_ctrl_q.RegWrite & ~done_err;
        // MEM/WB advances on every non-stalled edge; wb_valid only pulses for real instructions.
        wb_valid_d = !stall && ex_valid_q;
        wb_ctrl_d  = stall ? wb_ctrl_q : done_ctrl;
        wb_alu_d   = stall ? wb_alu_q : ex_alu_q;
        wb_mem_d   = stall ? wb_mem_q : (busy && dmem_gnt && ex_ctrl_q.MemRead) ? load_data : 32'd0;
        wb_pc_d    = stall ? wb_pc_q : ex_pc_q;
        wb_rd_d    = stall ? wb_rd_q : ex_rd_q;
        wb_err_d   = stall ? wb_err_q : done_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_alu_q   <= '0;
            ex_wd_q    <= '0;
            ex_pc_q    <= '0;
            ex_rd_q    <= '0;
            ex_f3_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_ctrl_q  <= '0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_pc_q    <= '0;
            wb_rd_q    <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_alu_q   <= ex_alu_d;
            ex_wd_q    <= ex_wd_d;
            ex_pc_q    <= ex_pc_d;
            ex_rd_q    <= ex_rd_d;
            ex_f3_q    <= ex_f3_d;
            wb_valid_q <= wb_valid_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_pc_q    <= wb_pc_d;
            wb_rd_q    <= wb_rd_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign stall_out       = stall;
    assign ex_mem_rd       = ex_rd_q;
    assign ex_mem_RegWrite = ex_ctrl_q.RegWrite;
    assign forward_ex_mem  = ex_alu_q;
    assign dmem_req        = busy;
    assign dmem_we         = busy & ex_ctrl_q.MemWrite;
    assign dmem_addr       = {ex_alu_q[31:2], 2'b00};
    assign dmem_wdata      = wdata_rep;
    assign dmem_be         = busy ? be : 4'h0;
    assign wb_valid        = wb_valid_q;
    assign control_out     = wb_ctrl_q;
    assign alu_data_out    = wb_alu_q;
    assign mem_data_out    = wb_mem_q;
    assign pc_out          = wb_pc_q;
    assign rd_out          = wb_rd_q;
    assign err_out         = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic checked against a transaction-level model.
// Expectations follow MEM_STAGE_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int T = 4;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    control_type control_in = '0;
    logic [31:0] alu_data = '0, memory_data = '0, pc_in = '0;
    logic [4:0]  rd_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        stall_out, ex_mem_RegWrite, dmem_req, dmem_we, wb_valid, err_out;
    logic [4:0]  ex_mem_rd, rd_out;
    logic [31:0] forward_ex_mem, dmem_addr, dmem_wdata, alu_data_out, mem_data_out, pc_out;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic [31:0] dmem_rdata = '0;
    control_type control_out;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .control_in(control_in),
        .alu_data(alu_data), .memory_data(memory_data), .pc_in(pc_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .stall_out(stall_out),
        .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite),
        .forward_ex_mem(forward_ex_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .control_out(control_out), .alu_data_out(alu_data_out),
        .mem_data_out(mem_data_out), .pc_out(pc_out), .rd_out(rd_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, mr, mw, rw, m2r;
        logic [31:0] alu, wd, pc, rdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          dly;
    } instr_t;

    int checks = 0;
    int failures = 0;
    instr_t cur, nx;
    int k;
    bit rnd;
    bit exp_wbv, e_err, e_rw, e_m2r, e_mr, e_chk_mem;
    logic [31:0] e_alu, e_pc, e_mem;
    logic [4:0]  e_rd;
    int stall_seen, req_seen;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(bit v, bit mr, bit mw, bit rw, bit m2r, logic [31:0] alu,
                                  logic [31:0] wd, logic [31:0] pc, logic [31:0] rdata,
                                  logic [4:0] rd, logic [2:0] f3, int dly);
        instr_t i;
        i.v = v; i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = m2r;
        i.alu = alu; i.wd = wd; i.pc = pc; i.rdata = rdata; i.rd = rd; i.f3 = f3; i.dly = dly;
        return i;
    endfunction

    function automatic instr_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        int kind;
        kind = $urandom_range(0, 2);
        i = mk($urandom_range(0, 7) != 0, kind == 1, kind == 2, kind == 1 || (kind == 0 && $urandom_range(0, 1) == 1),
               kind == 1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 3'($urandom), $urandom_range(0, 5));
        if (!i.v) i.mr = $urandom_range(0, 1) == 1;
        return i;
    endfunction

    function automatic instr_t next_instr();
        return rnd ? rnd_instr() : bubble();
    endfunction

    function automatic bit is_mem(instr_t i);
        return i.v && (i.mr || i.mw);
    endfunction

    function automatic bit trapped(instr_t i);
        return TRAP && is_mem(i) && ((i.f3[1] && i.alu[1:0] != 2'b00) || (i.f3[1:0] == 2'b01 && i.alu[0]));
    endfunction

    function automatic logic [31:0] load_exp(logic [2:0] f3, logic [1:0] a, logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'd0) return b | (b[7] ? 32'hFFFF_FF00 : 32'h0);
        if (f3 == 3'd1) return h | (h[15] ? 32'hFFFF_0000 : 32'h0);
        if (f3 == 3'd4) return b;
        if (f3 == 3'd5) return h;
        return d;
    endfunction

    function automatic logic [3:0] be_exp(logic [2:0] f3, logic [1:0] a);
        if (f3[1]) return 4'hF;
        if (f3[0]) return 4'b0011 << (2 * a[1]);
        return 4'b0001 << a;
    endfunction

    function automatic logic [31:0] wdata_exp(logic [2:0] f3, logic [31:0] d);
        if (f3[1]) return d;
        if (f3[0]) return d[15:0] * 32'h0001_0001;
        return d[7:0] * 32'h0101_0101;
    endfunction

    task automatic drive(input instr_t i);
        ex_valid = i.v;
        control_in.RegWrite = i.rw;
        control_in.MemtoReg = i.m2r;
        control_in.MemRead = i.mr;
        control_in.MemWrite = i.mw;
        alu_data = i.alu; memory_data = i.wd; pc_in = i.pc; rd_in = i.rd; funct3_in = i.f3;
    endtask

    task automatic clr_stats();
        stall_seen = 0; req_seen = 0; last_addr = 'x; last_wdata = 'x; last_be = 'x; last_we = 1'bx;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic run_cycle();
        bit b, g, to, st;
        chk("wb_valid", wb_valid, exp_wbv);
        if (exp_wbv) begin
            chk("rd_out", rd_out, e_rd);
            chk("alu_data_out", alu_data_out, e_alu);
            chk("pc_out", pc_out, e_pc);
            chk("err_out", err_out, e_err);
            chk("wb_RegWrite", control_out.RegWrite, e_rw);
            chk("wb_MemtoReg", control_out.MemtoReg, e_m2r);
            chk("wb_MemRead", control_out.MemRead, e_mr);
            if (e_chk_mem) chk("mem_data_out", mem_data_out, e_mem);
        end
        chk("ex_mem_rd", ex_mem_rd, cur.rd);
        chk("forward_ex_mem", forward_ex_mem, cur.alu);
        chk("ex_mem_RegWrite", ex_mem_RegWrite, cur.v && cur.rw);
        b  = is_mem(cur) && !trapped(cur);
        g  = b && k == cur.dly;
        to = b && !g && k == T - 1;
        st = b && !g && !to;
        dmem_gnt = b ? g : ($urandom_range(0, 1) == 1);
        dmem_rdata = g ? cur.rdata : $urandom;
        drive(st ? rnd_instr() : nx);
        #1;
        chk("dmem_req", dmem_req, b);
        chk("stall_out", stall_out, st);
        if (b) begin
            chk("dmem_addr", dmem_addr, {cur.alu[31:2], 2'b00});
            chk("dmem_be", dmem_be, be_exp(cur.f3, cur.alu[1:0]));
            chk("dmem_we", dmem_we, cur.mw);
            if (cur.mw) chk("dmem_wdata", dmem_wdata, wdata_exp(cur.f3, cur.wd));
            req_seen++;
            last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
        end
        stall_seen += int'(stall_out);
        if (st) begin
            exp_wbv = 1'b0;
            k++;
        end else begin
            exp_wbv = cur.v;
            e_rd = cur.rd; e_alu = cur.alu; e_pc = cur.pc;
            e_err = to || trapped(cur);
            e_rw = cur.rw && !e_err; e_m2r = cur.m2r; e_mr = cur.mr;
            e_chk_mem = cur.mr && !e_err;
            e_mem = load_exp(cur.f3, cur.alu[1:0], cur.rdata);
            cur = nx;
            k = 0;
            nx = next_instr();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_wb(input int lim, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < lim) begin
            run_cycle();
            n++;
            seen = wb_valid === 1'b1;
        end
        chk("wb_arrives", seen, 1'b1);
    endtask

    initial begin
        int n;
        rnd = 1'b0;
        cur = bubble(); nx = bubble(); k = 0; exp_wbv = 1'b0;
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_err", err_out, 0);
        chk("rst_alu_out", alu_data_out, 0);
        chk("rst_ex_mem_rd", ex_mem_rd, 0);
        rst = 1'b1;

        nx = mk(1, 0, 0, 1, 0, 32'h10, 32'h0, 32'h1000, 32'h0, 5'd5, 3'd0, 0);
        clr_stats();
        run_until_wb(10, n);
        chk("add_latency", n, 2);
        chk("add_alu", alu_data_out, 32'h10);
        chk("add_rd", rd_out, 5);
        chk("add_stall", stall_seen, 0);

        nx = mk(1, 1, 0, 1, 1, 32'h103, 32'h0, 32'h2000, 32'h80FF_FF7F, 5'd7, 3'd0, 3);
        clr_stats();
        run_until_wb(12, n);
        chk("lb_stall_cycles", stall_seen, 3);
        chk("lb_req_cycles", req_seen, 4);
        chk("lb_addr", last_addr, 32'h100);
        chk("lb_data", mem_data_out, 32'hFFFF_FF80);
        chk("lb_err", err_out, 0);

        nx = mk(1, 0, 1, 0, 0, 32'h202, 32'h0000_ABCD, 32'h3000, 32'h0, 5'd0, 3'd1, 0);
        clr_stats();
        run_until_wb(10, n);
        chk("sh_be", last_be, 4'b1100);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_we", last_we, 1);
        chk("sh_stall", stall_seen, 0);

        nx = mk(1, 1, 0, 1, 1, 32'h40, 32'h0, 32'h4000, 32'h1234_5678, 5'd9, 3'd2, 9);
        clr_stats();
        run_until_wb(12, n);
        chk("to_req_cycles", req_seen, 4);
        chk("to_stall_cycles", stall_seen, 3);
        chk("to_err", err_out, 1);
        chk("to_regwrite", control_out.RegWrite, 0);
        run_cycle();
        chk("to_stall_after", stall_out, 0);

        nx = mk(1, 1, 0, 1, 1, 32'h101, 32'h0, 32'h5000, 32'hCAFE_F00D, 5'd3, 3'd2, 0);
        clr_stats();
        run_until_wb(10, n);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        chk("mis_req", req_seen, 0);
        chk("mis_latency", n, 2);
        chk("mis_err", err_out, 1);
        chk("mis_regwrite", control_out.RegWrite, 0);
`else
        chk("mis_addr", last_addr, 32'h100);
        chk("mis_be", last_be, 4'hF);
        chk("mis_err", err_out, 0);
`endif

        nx = mk(1, 1, 0, 1, 1, 32'h300, 32'h0, 32'h6000, 32'h0, 5'd4, 3'd2, 9);
        run_cycle();
        run_cycle();
        chk("rst_busy_req_before", dmem_req, 1);
        rst = 1'b0;
        dmem_gnt = 1'b0;
        drive(bubble());
        #1;
        chk("rst_busy_req", dmem_req, 0);
        chk("rst_busy_stall", stall_out, 0);
        chk("rst_busy_wb_valid", wb_valid, 0);
        chk("rst_busy_ctrl", control_out, 0);
        chk("rst_busy_ex_rd", ex_mem_rd, 0);
        chk("rst_busy_fwd", forward_ex_mem, 0);
        chk("rst_busy_pc", pc_out, 0);
        chk("rst_busy_be", dmem_be, 0);
        cur = bubble(); nx = bubble(); k = 0; exp_wbv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_gnt = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("late_gnt_wb_valid", wb_valid, 0);
            chk("late_gnt_req", dmem_req, 0);
            chk("late_gnt_err", err_out, 0);
        end
        dmem_gnt = 1'b0;

        rnd = 1'b1;
        nx = next_instr();
        repeat (800) run_cycle();
        rnd = 1'b0;
        repeat (12) run_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
